// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcodes, FSM encoding and decode helper for seq_alu
// Build option: ALU_DIV_EN enables the iterative divider.
package seq_alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_LUI  = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01111;
    localparam logic [4:0] ALU_MULU = 5'b10000;
    localparam logic [4:0] ALU_MUL  = 5'b10010;
    localparam logic [4:0] ALU_DIVU = 5'b10001;
    localparam logic [4:0] ALU_DIV  = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Without the divider, divide opcodes fall back to a single-cycle trap.
    function automatic logic is_multi(input logic [4:0] aluc);
`ifdef ALU_DIV_EN
        return aluc[4];
`else
        return aluc[4] & ~aluc[0];
`endif
    endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// rtl/seq_alu_shifter.sv - combinational log-stage barrel shifter for seq_alu
module seq_alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [SHW-1:0]   amount,
    input  logic             right,
    input  logic             arith,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        for (int i = 0; i < SHW; i++) begin
            if (amount[i]) begin
                if (!right)
                    result = result << (1 << i);
                else if (arith)
                    result = $signed(result) >>> (1 << i);
                else
                    result = result >> (1 << i);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with iterative multiply/divide and Start/Busy/Done handshake
// Build option: ALU_DIV_EN enables the divide datapath and DIV state.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [4:0]       Aluc,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Hi,
    output logic             Z,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic             accept, last_step;
    logic [WIDTH-1:0] r_q, hi_q;
    logic             v_q;
    logic [WIDTH-1:0] acc, mq, mcand;
    logic [CW-1:0]    cnt;
    logic             neg_lo;
`ifdef ALU_DIV_EN
    logic             neg_hi, div_zero, div_ovf;
`endif

    assign accept    = Start && (state == ST_IDLE || state == ST_FIN);
    assign last_step = (cnt == CW'(1));

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nx = ST_IDLE;
                if (Start) begin
                    if (!is_multi(Aluc))
                        state_nx = ST_FIN;
`ifdef ALU_DIV_EN
                    else if (Aluc[0])
                        state_nx = ST_DIV;
`endif
                    else
                        state_nx = ST_MUL;
                end
            end
            ST_MUL: if (last_step) state_nx = ST_FIN;
`ifdef ALU_DIV_EN
            ST_DIV: if (last_step) state_nx = ST_FIN;
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            ST_MUL: Busy = 1'b1;
`ifdef ALU_DIV_EN
            ST_DIV: Busy = 1'b1;
`endif
            ST_FIN: Done = 1'b1;
            default: ;
        endcase
    end

    logic [WIDTH-1:0] sum_xy, dif_xy, sh_out, sc_r;
    logic             sc_v;

    assign sum_xy = X + Y;
    assign dif_xy = X - Y;

    seq_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .value  (Y),
        .amount (X[SHW-1:0]),
        .right  (Aluc[2]),
        .arith  (Aluc[3]),
        .result (sh_out)
    );

    always_comb begin
        sc_r = '0;
        sc_v = 1'b0;
        if (Aluc[4]) begin
            // only reaches the register file as the unsupported-divide trap
            sc_v = 1'b1;
        end else begin
            case (Aluc[1:0])
                2'b00: begin
                    if (Aluc[2]) begin
                        sc_r = dif_xy;
                        sc_v = (X[WIDTH-1] != Y[WIDTH-1]) && (dif_xy[WIDTH-1] != X[WIDTH-1]);
                    end else begin
                        sc_r = sum_xy;
                        sc_v = (X[WIDTH-1] == Y[WIDTH-1]) && (sum_xy[WIDTH-1] != X[WIDTH-1]);
                    end
                end
                2'b01:   sc_r = Aluc[2] ? (X | Y) : (X & Y);
                2'b10:   sc_r = Aluc[2] ? {Y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : (X ^ Y);
                default: sc_r = sh_out;
            endcase
        end
    end

    logic             sgn_x, sgn_y;
    logic [WIDTH-1:0] mag_x, mag_y;

    assign sgn_x = Aluc[1] & X[WIDTH-1];
    assign sgn_y = Aluc[1] & Y[WIDTH-1];
    assign mag_x = sgn_x ? -X : X;
    assign mag_y = sgn_y ? -Y : Y;

    // One adder serves both loops: add for shift-add multiply, subtract for restoring divide.
    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_cin;
    logic [WIDTH-1:0] acc_n, mq_n;

    assign add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        add_a   = {1'b0, acc};
        add_b   = mq[0] ? {1'b0, mcand} : '0;
        add_cin = 1'b0;
`ifdef ALU_DIV_EN
        if (state == ST_DIV) begin
            add_a   = {acc, mq[WIDTH-1]};
            add_b   = ~{1'b0, mcand};
            add_cin = 1'b1;
        end
`endif
    end

    always_comb begin
        acc_n = add_sum[WIDTH:1];
        mq_n  = {add_sum[0], mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        if (state == ST_DIV) begin
            // a set top bit of the trial dividend always clears the divisor
            if (add_a[WIDTH] | ~add_sum[WIDTH]) begin
                acc_n = add_sum[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = add_a[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_r, fin_hi;
    logic               fin_v;

    assign prod = neg_lo ? -{acc_n, mq_n} : {acc_n, mq_n};

    always_comb begin
        fin_r  = prod[WIDTH-1:0];
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_v  = 1'b0;
`ifdef ALU_DIV_EN
        if (state == ST_DIV) begin
            fin_r  = div_zero ? '1 : (neg_lo ? -mq_n : mq_n);
            fin_hi = neg_hi ? -acc_n : acc_n;
            fin_v  = div_zero | div_ovf;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_q      <= '0;
            hi_q     <= '0;
            v_q      <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg_lo   <= 1'b0;
`ifdef ALU_DIV_EN
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
`endif
        end else if (accept) begin
            if (!is_multi(Aluc)) begin
                r_q  <= sc_r;
                hi_q <= '0;
                v_q  <= sc_v;
            end else begin
                acc      <= '0;
                mq       <= mag_x;
                mcand    <= mag_y;
                cnt      <= CW'(WIDTH);
                neg_lo   <= sgn_x ^ sgn_y;
`ifdef ALU_DIV_EN
                neg_hi   <= sgn_x;
                div_zero <= (Y == '0);
                div_ovf  <= Aluc[1] && (X == {1'b1, {(WIDTH-1){1'b0}}}) && (Y == '1);
`endif
            end
        end else if (Busy) begin
            acc <= acc_n;
            mq  <= mq_n;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                r_q  <= fin_r;
                hi_q <= fin_hi;
                v_q  <= fin_v;
            end
        end
    end

    assign R  = r_q;
    assign Hi = hi_q;
    assign V  = v_q;
    assign Z  = (r_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with a behavioural reference model
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic         Clk = 1'b0;
    logic         Clrn = 1'b0;
    logic         Start = 1'b0;
    logic [4:0]   Aluc = '0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic [W-1:0] R, Hi;
    logic         Z, V, Busy, Done;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .Clk(Clk), .Clrn(Clrn), .Start(Start), .Aluc(Aluc), .X(X), .Y(Y),
        .R(R), .Hi(Hi), .Z(Z), .V(V), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         v;
        logic         multi;
    } exp_t;

    function automatic exp_t ref_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, s, q, rm;
        logic [63:0] up;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        if (!op[4]) begin
            case (op[1:0])
                2'b00: begin
                    s   = op[2] ? sx - sy : sx + sy;
                    e.r = s[W-1:0];
                    e.v = (s > SMAX) || (s < SMIN);
                end
                2'b01: e.r = op[2] ? (x | y) : (x & y);
                2'b10: e.r = op[2] ? {y[15:0], 16'h0000} : (x ^ y);
                default: begin
                    if (!op[2])     e.r = y << x[4:0];
                    else if (op[3]) e.r = $signed(y) >>> x[4:0];
                    else            e.r = y >> x[4:0];
                end
            endcase
        end else if (!op[0]) begin
            e.multi = 1'b1;
            if (op[1]) up = sx * sy;
            else       up = {32'h0, x} * {32'h0, y};
            e.r  = up[31:0];
            e.hi = up[63:32];
        end else begin
`ifdef ALU_DIV_EN
            e.multi = 1'b1;
            if (y == 0) begin
                e.r  = '1;
                e.hi = x;
                e.v  = 1'b1;
            end else if (op[1]) begin
                q    = sx / sy;
                rm   = sx % sy;
                e.r  = q[W-1:0];
                e.hi = rm[W-1:0];
                e.v  = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
            end else begin
                e.r  = x / y;
                e.hi = x % y;
            end
`else
            e.v = 1'b1;
`endif
        end
        return e;
    endfunction

    exp_t         cur, pend;
    logic         m_busy = 1'b0, m_done = 1'b0;
    int           busy_left = 0;
    logic [W-1:0] exp_r = '0, exp_hi = '0;
    logic         exp_v = 1'b0;

    always_comb cur = ref_op(Aluc, X, Y);

    // Cycle-level model: a multi-cycle op keeps Busy for W cycles, then one Done cycle.
    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            busy_left <= 0;
            exp_r     <= '0;
            exp_hi    <= '0;
            exp_v     <= 1'b0;
        end else if (m_busy) begin
            m_done    <= (busy_left == 1);
            m_busy    <= (busy_left != 1);
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                exp_r  <= pend.r;
                exp_hi <= pend.hi;
                exp_v  <= pend.v;
            end
        end else if (Start) begin
            if (cur.multi) begin
                m_busy    <= 1'b1;
                m_done    <= 1'b0;
                busy_left <= W;
                pend      <= cur;
            end else begin
                m_done <= 1'b1;
                exp_r  <= cur.r;
                exp_hi <= cur.hi;
                exp_v  <= cur.v;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk1("model_busy", Busy, m_busy);
        chk1("model_done", Done, m_done);
        chk("model_r", R, exp_r);
        chk("model_hi", Hi, exp_hi);
        chk1("model_v", V, exp_v);
        chk1("model_z", Z, exp_r == '0);
    end

    task automatic start_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge Clk);
        Start = 1'b1;
        Aluc  = op;
        X     = x;
        Y     = y;
        @(negedge Clk);
        Start = 1'b0;
        Aluc  = 5'($urandom);
        X     = $urandom;
        Y     = $urandom;
    endtask

    task automatic wait_done(output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!Done && n < 100) begin
            if (Busy) busy_cycles++;
            @(negedge Clk);
            n++;
        end
        chk1("done_within_budget", Done, 1'b1);
    endtask

    logic [4:0]   t_op [8];
    logic [W-1:0] t_x  [8];
    logic [W-1:0] t_y  [8];
    int           bc;
    int           done_seen;

    initial begin
        t_op[0] = ALU_AND; t_x[0] = 32'hF0F0_1234; t_y[0] = 32'h0FF0_FFFF;
        t_op[1] = ALU_OR;  t_x[1] = 32'hF000_0001; t_y[1] = 32'h0000_8000;
        t_op[2] = ALU_XOR; t_x[2] = 32'hAAAA_5555; t_y[2] = 32'hFFFF_0000;
        t_op[3] = ALU_LUI; t_x[3] = 32'h0000_0000; t_y[3] = 32'h1234_ABCD;
        t_op[4] = ALU_SLL; t_x[4] = 32'h0000_0023; t_y[4] = 32'h0000_0007;
        t_op[5] = ALU_SRL; t_x[5] = 32'h0000_001F; t_y[5] = 32'h8000_0000;
        t_op[6] = ALU_SUB; t_x[6] = 32'h8000_0000; t_y[6] = 32'h0000_0001;
        t_op[7] = 5'b01000; t_x[7] = 32'hFFFF_FFFF; t_y[7] = 32'h8000_0000;

        repeat (2) @(negedge Clk);
        chk("rst_r", R, 32'h0);
        chk("rst_hi", Hi, 32'h0);
        chk1("rst_z", Z, 1'b1);
        chk1("rst_v", V, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        #2 Clrn = 1'b1;

        start_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        chk1("add_done", Done, 1'b1);
        chk("add_r", R, 32'h8000_0000);
        chk1("add_v", V, 1'b1);
        chk1("add_z", Z, 1'b0);

        start_op(ALU_SUB, 32'd5, 32'd5);
        chk("sub_r", R, 32'h0);
        chk1("sub_z", Z, 1'b1);
        chk1("sub_v", V, 1'b0);

        start_op(ALU_SRA, 32'd4, 32'h8000_0000);
        chk("sra_r", R, 32'hF800_0000);

        for (int i = 0; i < 8; i++) start_op(t_op[i], t_x[i], t_y[i]);
        chk("add_ovf_r", R, 32'h7FFF_FFFF);
        chk1("add_ovf_v", V, 1'b1);

        start_op(ALU_LUI, 32'h0, 32'h1234_ABCD);
        chk("lui_r", R, 32'hABCD_0000);

        start_op(ALU_MUL, 32'hFFFF_FFFD, 32'd7);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Aluc = ALU_ADD; X = 32'd1; Y = 32'd1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(bc);
        chk("mul_r", R, 32'hFFFF_FFEB);
        chk("mul_hi", Hi, 32'hFFFF_FFFF);
        chk1("mul_v", V, 1'b0);

        start_op(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc);
        chk("mulu_busy_cycles", W'(bc), 32'd32);
        chk("mulu_r", R, 32'h0000_0001);
        chk("mulu_hi", Hi, 32'hFFFF_FFFE);

        start_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(bc);
`ifdef ALU_DIV_EN
        chk("div_r", R, 32'hFFFF_FFFD);
        chk("div_hi", Hi, 32'hFFFF_FFFF);
`else
        chk("div_trap_r", R, 32'h0);
        chk1("div_trap_v", V, 1'b1);
`endif
        start_op(ALU_DIVU, 32'd9, 32'd0);
        wait_done(bc);
`ifdef ALU_DIV_EN
        chk("divu0_r", R, 32'hFFFF_FFFF);
        chk("divu0_hi", Hi, 32'd9);
        chk1("divu0_v", V, 1'b1);
`else
        chk("divu_trap_hi", Hi, 32'h0);
`endif
        start_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc);
        start_op(ALU_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(bc);
        start_op(ALU_DIVU, 32'd100, 32'd7);
        wait_done(bc);
        start_op(ALU_DIV, 32'hFFFF_FFF8, 32'd0);
        wait_done(bc);

        start_op(ALU_MULU, 32'd5, 32'd6);
        wait_done(bc);
        Start = 1'b1; Aluc = ALU_ADD; X = 32'd10; Y = 32'd20;
        @(negedge Clk);
        Start = 1'b0;
        chk1("fin_accept_done", Done, 1'b1);
        chk("fin_accept_r", R, 32'd30);

        start_op(ALU_MUL, 32'd3, 32'd4);
        repeat (9) @(negedge Clk);
        #2 Clrn = 1'b0;
        @(negedge Clk);
        chk("midrst_r", R, 32'h0);
        chk1("midrst_busy", Busy, 1'b0);
        chk1("midrst_done", Done, 1'b0);
        @(negedge Clk);
        #2 Clrn = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        chk("midrst_no_done", W'(done_seen), 32'd0);
        start_op(ALU_ADD, 32'd1, 32'd2);
        chk("post_rst_add", R, 32'd3);

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
